// File: rtl/step_motor_pkg.sv
// ============================================================================
// Module   : step_motor_pkg
// Brief    : Shared widths and FSM state encoding for step_motor and its decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package step_motor_pkg;

  localparam int C_STEP_NUMBER_WIDTH = 16;
  localparam int C_SPEED_DATA_WIDTH  = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module   : sync_edge
// Brief    : Two-flop synchronizer with a rising-edge detector on its output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/step_pulse_decoder.sv
// ============================================================================
// Module   : step_pulse_decoder
// Brief    : Rebuilds position, step period and moving state from drive/dir pins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module step_pulse_decoder #(
  parameter int C_STEP_NUMBER_WIDTH = step_motor_pkg::C_STEP_NUMBER_WIDTH,
  parameter int C_SPEED_DATA_WIDTH  = step_motor_pkg::C_SPEED_DATA_WIDTH,
  parameter int C_IDLE_TIMEOUT      = 1000,
  parameter int C_DIR_SETUP         = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           m_drive,
  input  logic                           m_dir,
  input  logic                           clr,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] min_pos,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] max_pos,
  output logic [C_STEP_NUMBER_WIDTH-1:0] position,
  output logic [C_STEP_NUMBER_WIDTH-1:0] step_cnt,
  output logic [C_SPEED_DATA_WIDTH-1:0]  period,
  output logic                           step_evt,
  output logic                           moving,
  output logic                           ntsign,
  output logic                           ptsign,
  output logic                           dir_err
);

  import step_motor_pkg::*;

  localparam int DSW = (C_DIR_SETUP > 0) ? $clog2(C_DIR_SETUP + 1) : 1;
  localparam logic [DSW-1:0]                c_dir_setup  = DSW'(C_DIR_SETUP);
  localparam logic [C_SPEED_DATA_WIDTH-1:0] c_timeout_m1 = C_SPEED_DATA_WIDTH'(C_IDLE_TIMEOUT - 1);

  logic                           w_drive_sync;
  logic                           w_rise;
  logic                           r_dir_meta;
  logic                           r_dir_sync;
  logic                           r_dir_prev;
  logic                           w_dir_chg;
  logic [DSW-1:0]                 w_dir_stable;
  logic [DSW-1:0]                 r_dir_stable;
  logic [C_SPEED_DATA_WIDTH-1:0]  r_gap;
  logic [C_SPEED_DATA_WIDTH-1:0]  r_period;
  logic [C_SPEED_DATA_WIDTH-1:0]  w_period_next;
  logic [C_STEP_NUMBER_WIDTH-1:0] r_pos;
  logic [C_STEP_NUMBER_WIDTH-1:0] r_cnt;
  logic                           r_step_evt;
  logic                           r_dir_err;
  state_t                         r_state;
  state_t                         w_state_next;

  sync_edge u_drive_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (m_drive),
    .o_sync  (w_drive_sync),
    .o_rise  (w_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir_meta <= 1'b0;
      r_dir_sync <= 1'b0;
      r_dir_prev <= 1'b0;
    end else begin
      r_dir_meta <= m_dir;
      r_dir_sync <= r_dir_meta;
      r_dir_prev <= r_dir_sync;
    end
  end

  // Stable count includes the current cycle, so a change zeroes it immediately.
  assign w_dir_chg    = r_dir_sync ^ r_dir_prev;
  assign w_dir_stable = w_dir_chg ? '0 : r_dir_stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir_stable <= '0;
      r_gap        <= '0;
      r_step_evt   <= 1'b0;
    end else begin
      r_dir_stable <= (w_dir_stable >= c_dir_setup) ? c_dir_setup : w_dir_stable + 1'b1;
      r_gap        <= w_rise ? '0 : ((&r_gap) ? r_gap : r_gap + 1'b1);
      r_step_evt   <= w_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_period <= '0;
    end else begin
      r_state  <= w_state_next;
      r_period <= w_period_next;
    end
  end

  // Timeout fires as the gap counter reaches the limit, so an edge landing there still wins.
  always_comb begin
    w_state_next  = r_state;
    w_period_next = r_period;
    case (r_state)
      ST_IDLE: begin
        w_period_next = '0;
        if (w_rise) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_rise) begin
          w_period_next = r_gap + 1'b1;
        end else if (r_gap >= c_timeout_m1) begin
          w_state_next  = ST_IDLE;
          w_period_next = '0;
        end
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_period_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_pos     <= '0;
      r_cnt     <= '0;
      r_dir_err <= 1'b0;
    end else begin
      if (w_rise) begin
        r_pos <= r_dir_sync ? r_pos + 1'b1 : r_pos - 1'b1;
        if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
        if (w_dir_stable < c_dir_setup) r_dir_err <= 1'b1;
      end
    end
  end

  assign position = r_pos;
  assign step_cnt = r_cnt;
  assign period   = r_period;
  assign step_evt = r_step_evt;
  assign moving   = (r_state == ST_RUN);
  assign dir_err  = r_dir_err;
  assign ntsign   = $signed(r_pos) < $signed(min_pos);
  assign ptsign   = $signed(r_pos) > $signed(max_pos);

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_decoder.sv
// ============================================================================
// Module   : tb_step_pulse_decoder
// Brief    : Scoreboard bench for step_pulse_decoder (position, period, flags).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_step_pulse_decoder;

  localparam int W = 16;
  localparam int S = 16;
  localparam int T = 1000;

  logic         clk = 1'b0;
  logic         reset, m_drive, m_dir, clr;
  logic [W-1:0] min_pos, max_pos, position, step_cnt;
  logic [S-1:0] period;
  logic         step_evt, moving, ntsign, ptsign, dir_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    int           when;
    logic [W-1:0] pos;
    logic [W-1:0] cnt;
    logic [S-1:0] per;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mdl_pos, mdl_cnt;
  logic         mdl_err;
  int           last_rise;
  int           last_evt;

  step_pulse_decoder #(
    .C_STEP_NUMBER_WIDTH (W),
    .C_SPEED_DATA_WIDTH  (S),
    .C_IDLE_TIMEOUT      (T),
    .C_DIR_SETUP         (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_drive  (m_drive),
    .m_dir    (m_dir),
    .clr      (clr),
    .min_pos  (min_pos),
    .max_pos  (max_pos),
    .position (position),
    .step_cnt (step_cnt),
    .period   (period),
    .step_evt (step_evt),
    .moving   (moving),
    .ntsign   (ntsign),
    .ptsign   (ptsign),
    .dir_err  (dir_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  exp_t e_mon;
  always @(negedge clk) begin
    if (step_evt === 1'b1) begin
      last_evt = cyc;
      if (sb.size() == 0) begin
        check("evt_extra", 32'd1, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        check("evt_cyc", cyc, e_mon.when);
        check("evt_pos", position, e_mon.pos);
        check("evt_cnt", step_cnt, e_mon.cnt);
        check("evt_period", period, e_mon.per);
      end
    end
  end

  // Drives one drive pulse starting at a negedge and queues what the decoder must report.
  task automatic pulse(input int hi, input int lo, input bit clr_hit);
    exp_t e;
    int   n;
    n = cyc;
    if (clr_hit) begin
      mdl_pos = '0;
      mdl_cnt = '0;
      mdl_err = 1'b0;
    end else begin
      mdl_pos = m_dir ? mdl_pos + 1'b1 : mdl_pos - 1'b1;
      if (mdl_cnt != '1) mdl_cnt = mdl_cnt + 1'b1;
    end
    e.when = n + 3;
    e.pos  = mdl_pos;
    e.cnt  = mdl_cnt;
    e.per  = (last_rise >= 0 && (n - last_rise) <= T) ? S'(n - last_rise) : '0;
    last_rise = n;
    sb.push_back(e);
    m_drive = 1'b1;
    for (int i = 1; i <= hi + lo; i++) begin
      @(negedge clk);
      if (i == hi) m_drive = 1'b0;
      if (clr_hit && i == 2) clr = 1'b1;
      if (clr_hit && i == 3) clr = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", sb.size(), 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mdl_pos = '0;
    mdl_cnt = '0;
    mdl_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; m_drive = 1'b0; m_dir = 1'b0; clr = 1'b0;
    min_pos = '0; max_pos = '0;
    mdl_pos = '0; mdl_cnt = '0; mdl_err = 1'b0;
    last_rise = -1; last_evt = 0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pos", position, 0);
    check("rst_cnt", step_cnt, 0);
    check("rst_period", period, 0);
    check("rst_evt", step_evt, 0);
    check("rst_moving", moving, 0);
    check("rst_ntsign", ntsign, 0);
    check("rst_ptsign", ptsign, 0);
    check("rst_dir_err", dir_err, 0);

    // Steady run, then idle timeout
    min_pos = 16'h8000; max_pos = 16'h7FFF; m_dir = 1'b1;
    repeat (5) @(negedge clk);
    repeat (30) pulse(5, 15, 1'b0);
    drain();
    check("run_pos", position, 30);
    check("run_cnt", step_cnt, 30);
    check("run_period", period, 20);
    check("run_moving", moving, 1);
    while (cyc < last_evt + T - 1) @(negedge clk);
    check("pre_timeout_moving", moving, 1);
    @(negedge clk);
    check("timeout_moving", moving, 0);
    check("timeout_period", period, 0);

    // Reverse through the lower limit
    do_clr();
    check("clr_pos", position, 0);
    repeat (2) pulse(3, 7, 1'b0);
    drain();
    check("start2_pos", position, 2);
    min_pos = '0; m_dir = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      pulse(3, 7, 1'b0);
      drain();
      check("neg_pos", position, mdl_pos);
      check("neg_ntsign", ntsign, (k >= 3));
      check("neg_ptsign", ptsign, 0);
    end
    check("neg_final", position, 16'hFFFD);

    // Upper limit at step 101
    max_pos = 16'd100; min_pos = 16'h8000; m_dir = 1'b1;
    do_clr();
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 101; k++) begin
      pulse(2, 2, 1'b0);
      if (k == 100) check("ptsign_at100", ptsign, 0);
      if (k == 101) check("ptsign_at101", ptsign, 1);
    end
    drain();
    check("lim_pos", position, 101);

    // Wrap 0x7FFF -> 0x8000
    do_clr();
    repeat (32767) pulse(1, 1, 1'b0);
    drain();
    check("pre_wrap_pos", position, 16'h7FFF);
    check("pre_wrap_ptsign", ptsign, 1);
    pulse(1, 1, 1'b0);
    drain();
    check("wrap_pos", position, 16'h8000);
    check("wrap_cnt", step_cnt, 16'h8000);
    check("wrap_ptsign", ptsign, 0);
    check("wrap_ntsign", ntsign, 0);

    // Direction setup violation, sticky until clr
    repeat (5) @(negedge clk);
    m_dir = 1'b0;
    @(negedge clk);
    mdl_err = 1'b1;
    pulse(3, 7, 1'b0);
    drain();
    check("dir_err_set", dir_err, mdl_err);
    check("dir_err_pos", position, mdl_pos);
    repeat (5) @(negedge clk);
    pulse(3, 7, 1'b0);
    drain();
    check("dir_err_sticky", dir_err, 1);
    do_clr();
    check("dir_err_clr", dir_err, 0);
    check("dir_err_clr_pos", position, 0);

    // clr coinciding with an edge
    pulse(3, 7, 1'b0);
    pulse(4, 6, 1'b1);
    drain();
    check("clr_hit_pos", position, 0);
    check("clr_hit_cnt", step_cnt, 0);
    check("clr_hit_period", period, 10);
    check("clr_hit_moving", moving, 1);

    // Reset mid-motion
    pulse(3, 7, 1'b0);
    drain();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_rise = -1; mdl_pos = '0; mdl_cnt = '0; mdl_err = 1'b0;
    @(negedge clk);
    check("mid_rst_moving", moving, 0);
    check("mid_rst_period", period, 0);
    check("mid_rst_pos", position, 0);
    check("mid_rst_cnt", step_cnt, 0);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/step_pulse_decoder.md
# step_pulse_decoder

Receive-side monitor for the step motor drive interface. It samples a motor's drive/dir pins and reconstructs what the motor actually did: signed position, step period (real-time speed) and moving state, plus limit and protocol-error flags. It sits on the m*_drive/m*_dir outputs of step_motor, either in a loopback bench or on board pins, and gives an independent check of commanded motion.

## Interface
- C_STEP_NUMBER_WIDTH, 16, width of position and limits (two's complement)
- C_SPEED_DATA_WIDTH, 16, width of the period counter and output
- C_IDLE_TIMEOUT, 1000, clk cycles with no step edge before the decoder returns to IDLE (must be less than 2^C_SPEED_DATA_WIDTH - 1)
- C_DIR_SETUP, 2, minimum synchronized cycles dir must be stable before a drive rising edge
- clk, in, 1, single clock; all logic on posedge
- reset, in, 1, synchronous, active-high
- m_drive, in, 1, step pulse from motor driver; a rising edge is one step
- m_dir, in, 1, direction: 1 = positive, 0 = negative
- clr, in, 1, synchronous clear of position, step_cnt and dir_err
- min_pos, in, C_STEP_NUMBER_WIDTH, lower soft limit (signed)
- max_pos, in, C_STEP_NUMBER_WIDTH, upper soft limit (signed)
- position, out, C_STEP_NUMBER_WIDTH, signed accumulated position
- step_cnt, out, C_STEP_NUMBER_WIDTH, unsigned edges since reset/clr, saturating
- period, out, C_SPEED_DATA_WIDTH, clk cycles between the last two edges; 0 when not measured
- step_evt, out, 1, one-cycle strobe per accepted edge
- moving, out, 1, 1 in RUN state
- ntsign, out, 1, position < min_pos (signed compare)
- ptsign, out, 1, position > max_pos (signed compare)
- dir_err, out, 1, sticky; dir violated its setup window

## Operation
- m_drive and m_dir each pass a 2-flop synchronizer. An edge is detected when the synced drive is 1 and its previous value was 0.
- On an edge: position += 1 if synced dir = 1, else position -= 1. Position wraps modulo 2^W with no saturation. step_cnt += 1, saturating at all-ones. step_evt = 1 for one cycle.
- A dir_stable counter resets to 0 whenever synced dir changes and saturates at C_DIR_SETUP. If an edge arrives while dir_stable < C_DIR_SETUP, dir_err is set and stays set. The step is still counted using the current dir.
- The gap counter increments every cycle, saturates at all-ones and resets to 0 on an edge.
- States:
  - IDLE: moving = 0, period = 0. On an edge, go to RUN; period stays 0 because the first edge has no reference.
  - RUN: moving = 1. On an edge, period is loaded with gap + 1 (cycles from the previous edge to this one). When gap reaches C_IDLE_TIMEOUT with no edge, go to IDLE and set period = 0.
- Edge and timeout in the same cycle: the edge wins and the state stays RUN.
- clr while an edge is in flight: clr wins. position = 0 and step_cnt = 0; that edge is dropped from the counts, but step_evt still fires and the period and state logic still update.
- ntsign and ptsign are combinational from the registered position and the limits. min_pos > max_pos is legal; both flags then follow their compares independently.
- Reset: all registers and synchronizers go to 0, state = IDLE, and every output is 0. Reset mid-motion discards all history.

## Timing
- Pin edge to step_evt: 3 cycles (2 synchronizer stages + edge register). position, step_cnt and period update in the same cycle as step_evt.
- The minimum resolvable pulse is high ≥ 1 clk and low ≥ 1 clk after synchronization; narrower pulses may be lost.
- With steady edges every N cycles, period = N from the second edge onward.
- moving falls C_IDLE_TIMEOUT cycles after the last step_evt, at which point period = 0.
- Flags follow position combinationally, with no extra latency.

## Structure
- Shared package step_motor_pkg holds:
  - state encoding (ST_IDLE, ST_RUN)
  - default widths, shared with step_motor (C_STEP_NUMBER_WIDTH, C_SPEED_DATA_WIDTH)
- Sub-module `sync_edge`: 2-flop synchronizer plus rising-edge detector, instantiated for drive. dir uses its synchronizer half only.
- The decoder top holds the counters, FSM and compares.

## Test plan
- Reset, then hold inputs idle → all outputs 0; state IDLE.
- dir = 1, 30 pulses every 20 cycles → position = 30, step_cnt = 30, period = 20 after the second edge, moving = 1. After 1000 idle cycles → moving = 0, period = 0.
- From position 2, dir = 0, 5 pulses with min_pos = 0 → position = -3 (0xFFFD); ntsign = 1 from the third step onward; ptsign = 0.
- max_pos = 100, dir = 1, 101 steps → ptsign asserts at step 101. Separately, position 0x7FFF plus 1 step → wraps to 0x8000.
- Toggle dir 1 cycle before a drive edge → dir_err = 1 and stays set. A subsequent clr → dir_err = 0, position = 0.
- Assert clr in the same cycle as a step_evt → position = 0, step_cnt = 0, step_evt still seen, period updated.
